lif_neuron_core: RTL and testbench
==================================

Name: lif_neuron_core

Overview:
Parametrised leaky integrate-and-fire neuron.
- Multi-synapse: N_SYN spike inputs, each with its own signed weight, so inhibitory synapses are supported.
- Membrane potential uses shift-based leak and saturating arithmetic.
- On a threshold crossing: registered one-cycle spike, reset to a programmable potential, then a programmable refractory period.
- Sits between the synapse fabric and the axon router; integration advances only on a timestep strobe, so many cores can share a global time base.

Parameters:
- N_SYN, 4, number of synapse inputs (1..16)
- V_W, 16, membrane potential width, unsigned
- W_W, 12, per-synapse weight width, signed two's complement
- SHIFT_W, 4, leak shift control width
- REF_W, 4, refractory counter width
- CNT_W, 8, spike counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- step  in  1  timestep strobe; one integration or refractory tick per cycle where high
- syn  in  N_SYN  presynaptic spike bits, sampled when step=1
- weights  in  N_SYN*W_W  packed signed weights; weight i is at [i*W_W +: W_W]
- leak_shift  in  SHIFT_W  leak amount; decay = V >> leak_shift; 0 = no leak
- threshold  in  V_W  firing threshold, unsigned
- v_reset  in  V_W  potential loaded after a spike
- refractory  in  REF_W  number of step ticks ignored after a spike
- cnt_clr  in  1  synchronous clear of spike_cnt
- spike  out  1  one-cycle registered spike pulse
- refrac  out  1  high while in the REFRACT state
- V  out  V_W  membrane potential register
- spike_cnt  out  CNT_W  saturating spike count

Behaviour:
- Reset (async, rst=1): V=0, spike=0, refrac=0, spike_cnt=0, state=INTEGRATE, ref counter=0.
- States: INTEGRATE, REFRACT. All registers hold when step=0, except that spike clears and cnt_clr is honoured.
- Synaptic sum:
  - syn_sum = signed sum of weight[i] for every i with syn[i]=1.
  - Sum width is W_W+$clog2(N_SYN)+1; no overflow is possible.
- Leak:
  - leaked = V - (V >> leak_shift) when leak_shift != 0; leaked = V when leak_shift = 0.
  - Shifts ≥ V_W give leaked = V - 0 = V; this is legal, not an error.
- Next potential: v_calc = leaked + syn_sum, computed signed at V_W+2 bits, then saturated. Negative results clamp to 0; results above 2^V_W-1 clamp to 2^V_W-1.
- INTEGRATE with step=1:
  - If v_calc ≥ threshold: V←v_reset, spike←1 on the next cycle, spike_cnt increments (saturating at all-ones). If refractory != 0, go to REFRACT with counter←refractory; else stay in INTEGRATE.
  - Otherwise: V←v_calc.
- REFRACT with step=1:
  - syn is ignored; V holds, with no leak.
  - Counter decrements. When the counter is 1 before the tick, go to INTEGRATE.
  - refractory=R therefore blocks exactly R step ticks.
- Threshold is compared against the post-update value v_calc, not the current V. Spike latency is 1 clk after the step edge.
- threshold=0 fires on every INTEGRATE step, including when V=0. This is legal.
- v_reset ≥ threshold does not cause a spike by itself. Crossing is evaluated only on the next INTEGRATE step.
- spike is high for exactly one cycle per firing, even with back-to-back step.
- cnt_clr=1 clears spike_cnt. If cnt_clr and a firing occur in the same cycle, spike_cnt becomes 1 (clear takes priority, then the increment applies).
- All config inputs (weights, leak_shift, threshold, v_reset, refractory) are sampled combinationally when step=1; changing them between steps is legal.
- Reset asserted mid-refractory or in the same cycle as a spike: everything returns to reset values immediately; no spike is emitted.

Decomposition:
- Package lif_pkg:
  - state enum lif_state_t {INTEGRATE, REFRACT}
  - sat_unsigned function (signed→unsigned V_W clamp)
  - default parameter constants
- Sub-module lif_leak: combinational, V and leak_shift → leaked. It is reused by future neuron variants.
- Synapse sum stays inline as a loop.

Test Plan:
- N_SYN=4, weights {10,20,30,40}, leak_shift=0, threshold=100, syn=4'b1111, one step → V=0 stays (v_calc=100 ≥ 100); spike=1 one clk later; spike_cnt=1; with refractory=0, state stays INTEGRATE.
- V=64, leak_shift=2, syn=0, two steps → V=48, then V=36; no spike with threshold=100.
- Weights {-50,0,0,0}, V=20, syn=4'b0001, step → V=0 (clamped at zero). Weights {2047,...}, V=65500, syn=4'b1111, threshold=65535 → V=v_reset and spike=1; non-firing variant with threshold>sum saturates V at 65535.
- refractory=3, fire, then 3 steps with syn=4'b1111 → V stays v_reset and refrac=1 for all 3; 4th step integrates and refrac=0.
- rst pulsed mid-REFRACT and again in the cycle after a crossing step → V=0, spike=0, refrac=0, spike_cnt=0 asynchronously, before the next clk edge.
- spike_cnt at 255 plus a firing → stays 255; cnt_clr together with a firing → spike_cnt=1.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire neuron family.
// Contents: neuron state enum, default parameter constants and a signed to
// unsigned saturating clamp.
package lif_pkg;

    localparam int unsigned LIF_N_SYN   = 4;
    localparam int unsigned LIF_V_W     = 16;
    localparam int unsigned LIF_W_W     = 12;
    localparam int unsigned LIF_SHIFT_W = 4;
    localparam int unsigned LIF_REF_W   = 4;
    localparam int unsigned LIF_CNT_W   = 8;

    typedef enum logic {
        INTEGRATE = 1'b0,
        REFRACT   = 1'b1
    } lif_state_t;

    // Clamp a signed value into the unsigned range [0, 2^w-1] (w <= 32).
    function automatic logic [31:0] sat_unsigned(input logic signed [63:0] x,
                                                 input int unsigned w);
        logic signed [63:0] lim;
        lim = (64'sd1 <<< w) - 64'sd1;
        if (x < 64'sd0)
            return 32'd0;
        else if (x > lim)
            return lim[31:0];
        else
            return x[31:0];
    endfunction

endpackage

// File: rtl/lif_neuron_core_leak.sv
// Shift-based membrane leak: leaked = V - (V >> shift), or V when shift = 0.
// Ports: i_v (potential), i_leak_shift (decay shift), o_leaked (result).
module lif_neuron_core_leak #(
    parameter int unsigned V_W     = 16,
    parameter int unsigned SHIFT_W = 4
) (
    input  logic [V_W-1:0]     i_v,
    input  logic [SHIFT_W-1:0] i_leak_shift,
    output logic [V_W-1:0]     o_leaked
);

    logic [V_W-1:0] w_decay;

    // Shifts at or beyond V_W naturally give zero decay.
    assign w_decay  = i_v >> i_leak_shift;
    // A zero shift would subtract all of V, so it means "no leak" instead.
    assign o_leaked = (i_leak_shift == '0) ? i_v : (i_v - w_decay);

endmodule

// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron core with signed multi-synapse input,
// saturating potential, registered spike, reset potential and refractory.
// Ports: clk/rst (async active-high), i_step timestep strobe, i_syn spike bits,
// i_weights packed signed weights, i_leak_shift, i_threshold, i_v_reset,
// i_refractory, i_cnt_clr; outputs o_spike, o_refrac, o_v, o_spike_cnt.
module lif_neuron_core
    import lif_pkg::*;
#(
    parameter int unsigned N_SYN   = LIF_N_SYN,
    parameter int unsigned V_W     = LIF_V_W,
    parameter int unsigned W_W     = LIF_W_W,
    parameter int unsigned SHIFT_W = LIF_SHIFT_W,
    parameter int unsigned REF_W   = LIF_REF_W,
    parameter int unsigned CNT_W   = LIF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_step,
    input  logic [N_SYN-1:0]       i_syn,
    input  logic [N_SYN*W_W-1:0]   i_weights,
    input  logic [SHIFT_W-1:0]     i_leak_shift,
    input  logic [V_W-1:0]         i_threshold,
    input  logic [V_W-1:0]         i_v_reset,
    input  logic [REF_W-1:0]       i_refractory,
    input  logic                   i_cnt_clr,
    output logic                   o_spike,
    output logic                   o_refrac,
    output logic [V_W-1:0]         o_v,
    output logic [CNT_W-1:0]       o_spike_cnt
);

    localparam int unsigned SUM_W  = W_W + $clog2(N_SYN) + 1;
    localparam int unsigned CALC_W = V_W + 2;

    lif_state_t              r_state;
    lif_state_t              w_state_nxt;
    logic [V_W-1:0]          r_v;
    logic [REF_W-1:0]        r_ref_cnt;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_spike;
    logic                    r_refrac;

    logic signed [SUM_W-1:0]  w_syn_sum;
    logic [V_W-1:0]           w_leaked;
    logic signed [CALC_W-1:0] w_v_calc;
    logic [V_W-1:0]           w_v_sat;
    logic                     w_cross;
    logic                     w_fire;
    logic [V_W-1:0]           w_v_nxt;
    logic [REF_W-1:0]         w_ref_nxt;
    logic [CNT_W-1:0]         w_cnt_nxt;

    // Signed sum of the weights of all active synapses.
    always_comb begin
        w_syn_sum = '0;
        for (int i = 0; i < N_SYN; i++) begin
            if (i_syn[i])
                w_syn_sum = w_syn_sum + SUM_W'($signed(i_weights[i*W_W +: W_W]));
        end
    end

    lif_neuron_core_leak #(
        .V_W     (V_W),
        .SHIFT_W (SHIFT_W)
    ) u_leak (
        .i_v          (r_v),
        .i_leak_shift (i_leak_shift),
        .o_leaked     (w_leaked)
    );

    // Two guard bits keep the sum exact before clamping.
    assign w_v_calc = $signed({2'b00, w_leaked}) + CALC_W'(w_syn_sum);
    assign w_v_sat  = V_W'(sat_unsigned(64'(w_v_calc), V_W));
    assign w_cross  = (w_v_sat >= i_threshold);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= INTEGRATE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        if (i_step) begin
            case (r_state)
                INTEGRATE: if (w_cross && (i_refractory != '0)) w_state_nxt = REFRACT;
                REFRACT:   if (r_ref_cnt <= REF_W'(1))           w_state_nxt = INTEGRATE;
                default:   w_state_nxt = INTEGRATE;
            endcase
        end
    end

    // Output / datapath next values.
    always_comb begin
        w_v_nxt   = r_v;
        w_ref_nxt = r_ref_cnt;
        w_fire    = 1'b0;
        if (i_step) begin
            case (r_state)
                INTEGRATE: begin
                    if (w_cross) begin
                        w_fire    = 1'b1;
                        w_v_nxt   = i_v_reset;
                        w_ref_nxt = i_refractory;
                    end else begin
                        w_v_nxt   = w_v_sat;
                    end
                end
                REFRACT: begin
                    if (r_ref_cnt != '0)
                        w_ref_nxt = r_ref_cnt - REF_W'(1);
                end
                default: w_ref_nxt = '0;
            endcase
        end
        // Clear first, then a same-cycle firing still counts.
        w_cnt_nxt = i_cnt_clr ? '0 : r_cnt;
        if (w_fire && (w_cnt_nxt != '1))
            w_cnt_nxt = w_cnt_nxt + CNT_W'(1);
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v       <= '0;
            r_ref_cnt <= '0;
            r_cnt     <= '0;
            r_spike   <= 1'b0;
            r_refrac  <= 1'b0;
        end else begin
            r_v       <= w_v_nxt;
            r_ref_cnt <= w_ref_nxt;
            r_cnt     <= w_cnt_nxt;
            r_spike   <= w_fire;
            r_refrac  <= (w_state_nxt == REFRACT);
        end
    end

    assign o_spike     = r_spike;
    assign o_refrac    = r_refrac;
    assign o_v         = r_v;
    assign o_spike_cnt = r_cnt;

endmodule

// File: tb/tb_lif_neuron_core.sv
module tb_lif_neuron_core;

    localparam int unsigned N_SYN = 4;
    localparam int unsigned W_W   = 12;
    localparam int VMAX           = 65535;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 step;
    logic [N_SYN-1:0]     syn;
    logic [N_SYN*W_W-1:0] weights;
    logic [3:0]           leak_shift;
    logic [15:0]          threshold;
    logic [15:0]          v_reset;
    logic [3:0]           refractory;
    logic                 cnt_clr;
    logic                 spike;
    logic                 refrac;
    logic [15:0]          v;
    logic [7:0]           spike_cnt;

    int w[N_SYN];
    int m_v, m_cnt, m_ref;
    bit m_spike;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lif_neuron_core dut (
        .clk          (clk),
        .rst          (rst),
        .i_step       (step),
        .i_syn        (syn),
        .i_weights    (weights),
        .i_leak_shift (leak_shift),
        .i_threshold  (threshold),
        .i_v_reset    (v_reset),
        .i_refractory (refractory),
        .i_cnt_clr    (cnt_clr),
        .o_spike      (spike),
        .o_refrac     (refrac),
        .o_v          (v),
        .o_spike_cnt  (spike_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".V"},      32'(v),         32'(m_v));
        chk({tag, ".spike"},  32'(spike),     32'(m_spike));
        chk({tag, ".refrac"}, 32'(refrac),    32'(m_ref > 0));
        chk({tag, ".cnt"},    32'(spike_cnt), 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_v = 0; m_cnt = 0; m_ref = 0; m_spike = 0;
    endtask

    // Behavioural neuron: one call per clock, using the inputs applied now.
    task automatic model_step();
        int  leaked, sum, vc;
        bit  fire;
        fire    = 0;
        m_spike = 0;
        if (step) begin
            if (m_ref > 0) begin
                m_ref--;
            end else begin
                leaked = (leak_shift == 0) ? m_v : m_v - (m_v >> leak_shift);
                sum = 0;
                for (int i = 0; i < N_SYN; i++) if (syn[i]) sum += w[i];
                vc = leaked + sum;
                if (vc < 0) vc = 0;
                if (vc > VMAX) vc = VMAX;
                if (vc >= int'(threshold)) begin
                    m_v = int'(v_reset);
                    fire = 1;
                    m_ref = int'(refractory);
                end else begin
                    m_v = vc;
                end
            end
        end
        if (cnt_clr) m_cnt = 0;
        if (fire && m_cnt < 255) m_cnt++;
        m_spike = fire;
    endtask

    task automatic tick(input string tag);
        for (int i = 0; i < N_SYN; i++) weights[i*W_W +: W_W] = W_W'(w[i]);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_w(input int a, input int b, input int c, input int d);
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; step = 0; syn = '0; weights = '0; leak_shift = 0;
        threshold = 16'd100; v_reset = 0; refractory = 0; cnt_clr = 0;
        set_w(0, 0, 0, 0);
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Exact threshold hit, no refractory.
        set_w(10, 20, 30, 40); syn = 4'b1111; step = 1;
        tick("fire_eq");
        step = 0; syn = 0;
        tick("after_fire");

        // Leak 64 -> 48 -> 36.
        set_w(64, 0, 0, 0); syn = 4'b0001; step = 1;
        tick("load64");
        syn = 0; leak_shift = 2;
        tick("leak1");
        tick("leak2");
        chk("leak2_value", 32'(v), 32'd36);
        step = 0;
        tick("hold");

        // Clamp at zero with an inhibitory synapse.
        hard_reset();
        leak_shift = 0; set_w(20, 0, 0, 0); syn = 4'b0001; step = 1;
        tick("load20");
        set_w(-50, 0, 0, 0);
        tick("clamp0");

        // Drive towards the top and saturate/fire at 65535.
        set_w(2047, 2047, 2047, 2047); syn = 4'b1111; threshold = 16'hFFFF;
        v_reset = 16'd1234;
        for (int k = 0; k < 10; k++) tick("sat_up");

        // Refractory of 3 blocks exactly 3 step ticks.
        hard_reset();
        set_w(10, 20, 30, 40); threshold = 16'd100; v_reset = 16'd7;
        refractory = 3; syn = 4'b1111;
        tick("ref_fire");
        step = 0;
        tick("ref_idle");
        step = 1;
        for (int k = 0; k < 3; k++) tick("ref_block");
        refractory = 0; threshold = 16'd500;
        tick("ref_done");

        // Async reset mid-refractory.
        refractory = 5; threshold = 16'd50;
        tick("ref2_fire");
        tick("ref2_in");
        hard_reset();
        // Async reset right after a crossing step.
        refractory = 0;
        tick("x_fire");
        hard_reset();

        // Counter saturation then clear-with-fire.
        threshold = 0; refractory = 0; syn = 0;
        for (int k = 0; k < 256; k++) begin
            for (int i = 0; i < N_SYN; i++) weights[i*W_W +: W_W] = W_W'(w[i]);
            model_step();
            @(posedge clk);
        end
        #1;
        check_all("cnt_sat");
        tick("cnt_sat2");
        cnt_clr = 1;
        tick("clr_fire");
        cnt_clr = 0;

        // Randomised traffic.
        hard_reset();
        for (int k = 0; k < 400; k++) begin
            step       = ($urandom_range(0, 3) != 0);
            syn        = 4'($urandom_range(0, 15));
            for (int i = 0; i < N_SYN; i++) w[i] = int'($urandom_range(0, 4095)) - 2048;
            leak_shift = 4'($urandom_range(0, 15));
            threshold  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 65535))
                                                     : 16'($urandom_range(0, 3000));
            v_reset    = 16'($urandom_range(0, 1500));
            refractory = 4'($urandom_range(0, 5));
            cnt_clr    = ($urandom_range(0, 31) == 0);
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
